// File: rtl/conv_enc_pkg.sv
// Shared constants and FSM encoding for the K=3 rate-1/2 (7,5) convolutional encoder.
package conv_enc_pkg;
  localparam int unsigned K        = 3;
  localparam int unsigned TAIL_LEN = K - 1;
  localparam logic [K-1:0] G1      = 3'b111;
  localparam logic [K-1:0] G0      = 3'b101;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_DATA  = 2'd1;
  localparam state_t ST_TAIL  = 2'd2;
  localparam state_t ST_FLUSH = 2'd3;
endpackage

// File: rtl/conv_enc_k3_core.sv
// K=3 trellis state register with combinational {g1,g0} output for the current input bit.
// Zero latency on the pair; state advances on i_step, i_clear has priority and zeroes the trellis.
module conv_enc_k3_core
  import conv_enc_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_u,
  input  logic       i_step,
  input  logic       i_clear,
  output logic [1:0] o_pair
);
  logic [K-2:0] r_s;
  logic [K-1:0] w_reg;

  // Tap vector ordered {u, s[1], s[0]} so the generator masks apply directly.
  assign w_reg  = {i_u, r_s};
  assign o_pair = {^(w_reg & G1), ^(w_reg & G0)};

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_s <= '0;
    end else if (i_clear) begin
      r_s <= '0;
    end else if (i_step) begin
      r_s <= {i_u, r_s[K-2:1]};
    end
  end
endmodule

// File: rtl/conv_enc_frame_ctrl.sv
// Frame sequencer for the (7,5) encoder: one symbol per accepted bit plus optional 2-bit zero tail.
// Symbol appears the cycle after its input handshake; a stalled sink freezes sym_out and drops in_ready.
module conv_enc_frame_ctrl
  import conv_enc_pkg::*;
#(
  parameter int FRAME_LEN_W = 16,
  parameter bit TAIL_EN     = 1'b1
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_start,
  input  logic [FRAME_LEN_W-1:0] i_frame_len,
  output logic                   o_busy,
  input  logic                   i_in_bit,
  input  logic                   i_in_valid,
  output logic                   o_in_ready,
  output logic [1:0]             o_sym_out,
  output logic                   o_sym_valid,
  input  logic                   i_sym_ready,
  output logic                   o_sym_last,
  output logic                   o_done
);
  state_t                 r_state;
  logic [FRAME_LEN_W-1:0] r_len;
  logic [FRAME_LEN_W-1:0] r_cnt;
  logic [1:0]             r_tail_cnt;
  logic [1:0]             r_sym;
  logic                   r_sym_valid;
  logic                   r_sym_last;
  logic                   r_busy;
  logic                   r_done;

  logic                   w_advance;
  logic                   w_in_hs;
  logic                   w_tail_step;
  logic                   w_start_ok;
  logic                   w_u;
  logic [1:0]             w_pair;
  logic [FRAME_LEN_W-1:0] w_cnt_nxt;

  assign w_advance   = !r_sym_valid || i_sym_ready;
  assign o_in_ready  = (r_state == ST_DATA) && w_advance;
  assign w_in_hs     = o_in_ready && i_in_valid;
  assign w_tail_step = (r_state == ST_TAIL) && w_advance;
  // The done cycle is already IDLE; a start there must not open a new frame.
  assign w_start_ok  = (r_state == ST_IDLE) && i_start && !r_done && (i_frame_len != '0);
  assign w_u         = w_in_hs && i_in_bit;
  assign w_cnt_nxt   = r_cnt + FRAME_LEN_W'(1);

  conv_enc_k3_core u_core (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_u     (w_u),
    .i_step  (w_in_hs || w_tail_step),
    .i_clear (w_start_ok),
    .o_pair  (w_pair)
  );

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state     <= ST_IDLE;
      r_len       <= '0;
      r_cnt       <= '0;
      r_tail_cnt  <= '0;
      r_sym       <= '0;
      r_sym_valid <= 1'b0;
      r_sym_last  <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_start_ok) begin
            r_len      <= i_frame_len;
            r_cnt      <= '0;
            r_tail_cnt <= '0;
            r_busy     <= 1'b1;
            r_state    <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (w_in_hs) begin
            r_sym       <= w_pair;
            r_sym_valid <= 1'b1;
            r_cnt       <= w_cnt_nxt;
            if (w_cnt_nxt == r_len) begin
              if (TAIL_EN) begin
                r_state <= ST_TAIL;
              end else begin
                r_sym_last <= 1'b1;
                r_state    <= ST_FLUSH;
              end
            end
          end else if (w_advance) begin
            r_sym_valid <= 1'b0;
          end
        end
        ST_TAIL: begin
          if (w_advance) begin
            r_sym       <= w_pair;
            r_sym_valid <= 1'b1;
            r_tail_cnt  <= r_tail_cnt + 2'd1;
            if (r_tail_cnt == 2'(TAIL_LEN - 1)) begin
              r_sym_last <= 1'b1;
              r_state    <= ST_FLUSH;
            end
          end
        end
        ST_FLUSH: begin
          if (r_sym_valid && i_sym_ready && r_sym_last) begin
            r_sym_valid <= 1'b0;
            r_sym_last  <= 1'b0;
            r_done      <= 1'b1;
            r_busy      <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_busy      = r_busy;
  assign o_sym_out   = r_sym;
  assign o_sym_valid = r_sym_valid;
  assign o_sym_last  = r_sym_last;
  assign o_done      = r_done;
endmodule
